// File: rtl/fifo_rd_serializer.sv
// rtl/fifo_rd_serializer.sv - FIFO read-side word-to-beat serializer with one-word prefetch
module fifo_rd_serializer #(
    parameter int DSIZE = 32,
    parameter int OSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [OSIZE-1:0] o_data,
    output logic             o_last
);

    localparam int RATIO = DSIZE / OSIZE;
    localparam int IW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

    // Shift stage: the word currently being emitted, beat by beat
    logic [DSIZE-1:0] sh_word_q, sh_word_d;
    logic             sh_vld_q,  sh_vld_d;
    logic [IW-1:0]    idx_q,     idx_d;

    // Prefetch stage: the next word, already popped from the FIFO
    logic [DSIZE-1:0] pf_word_q, pf_word_d;
    logic             pf_vld_q,  pf_vld_d;

    logic xfer;
    logic wdone;
    logic sh_load;

    // Output beat selection from the shift word by the current beat index
    always_comb begin
        o_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (idx_q == IW'(i)) begin
                o_data = sh_word_q[i*OSIZE +: OSIZE];
            end
        end
    end

    assign o_valid = sh_vld_q;
    assign o_last  = sh_vld_q & (idx_q == LAST_IDX);
    assign xfer    = sh_vld_q & o_ready;
    assign wdone   = xfer & o_last;
    assign sh_load = ~sh_vld_q | wdone;

    // Pop whenever some stage will have room at this edge; never on an empty FIFO
    assign rinc = rrst_n & ~rempty & (~pf_vld_q | ~sh_vld_q | wdone);

    // Next-state for both stages: refill shift stage first, prefetch takes the remainder
    always_comb begin
        sh_word_d = sh_word_q;
        sh_vld_d  = sh_vld_q;
        idx_d     = idx_q;
        pf_word_d = pf_word_q;
        pf_vld_d  = pf_vld_q;

        if (sh_load) begin
            if (pf_vld_q) begin
                // prefetch drains into shift stage and may refill in the same cycle
                sh_word_d = pf_word_q;
                sh_vld_d  = 1'b1;
                idx_d     = '0;
                pf_vld_d  = rinc;
                if (rinc) begin
                    pf_word_d = rdata;
                end
            end else if (rinc) begin
                // both stages empty/draining: bypass the prefetch
                sh_word_d = rdata;
                sh_vld_d  = 1'b1;
                idx_d     = '0;
            end else begin
                sh_vld_d  = 1'b0;
                idx_d     = '0;
            end
        end else begin
            if (xfer) begin
                idx_d = idx_q + IW'(1);
            end
            if (rinc) begin
                // shift stage busy mid-word: park the popped word
                pf_word_d = rdata;
                pf_vld_d  = 1'b1;
            end
        end
    end

    // State registers; reset discards any partial and prefetched word
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            sh_word_q <= '0;
            sh_vld_q  <= 1'b0;
            idx_q     <= '0;
            pf_word_q <= '0;
            pf_vld_q  <= 1'b0;
        end else begin
            sh_word_q <= sh_word_d;
            sh_vld_q  <= sh_vld_d;
            idx_q     <= idx_d;
            pf_word_q <= pf_word_d;
            pf_vld_q  <= pf_vld_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// tb/tb_fifo_rd_serializer.sv - directed self-checking bench for fifo_rd_serializer
module tb_fifo_rd_serializer;

    logic        rclk = 1'b0;
    logic        rrst_n;

    logic        rempty0, rinc0, v0, r0, l0;
    logic [31:0] rdata0;
    logic [7:0]  d0;

    logic        rempty1, rinc1, v1, r1, l1;
    logic [31:0] rdata1, d1;

    logic [31:0] f0[$], f1[$], exp_w[$];
    logic [31:0] g0d[$], g1d[$];
    logic        g0l[$], g1l[$];
    int          g0c[$], g1c[$];

    int   n_cmp, n_bad, cyc, pops0, first_done_pops, stable_viol, empty_viol, budget, c0;
    logic pend0, pend1, pv0, pr0, pl0;
    logic [7:0]  pd0;
    logic [31:0] tmp;

    always #5 rclk = ~rclk;

    fifo_rd_serializer #(.DSIZE(32), .OSIZE(8)) u_dut4 (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty0), .rdata(rdata0), .rinc(rinc0),
        .o_valid(v0), .o_ready(r0), .o_data(d0), .o_last(l0)
    );

    fifo_rd_serializer #(.DSIZE(32), .OSIZE(32)) u_dut1 (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty1), .rdata(rdata1), .rinc(rinc1),
        .o_valid(v1), .o_ready(r1), .o_data(d1), .o_last(l1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        rempty0 = (f0.size() == 0);
        rdata0  = rempty0 ? 32'h0 : f0[0];
        rempty1 = (f1.size() == 0);
        rdata1  = rempty1 ? 32'h0 : f1[0];
    endtask

    // sample on falling edge, apply FIFO pops just after the rising edge
    task automatic tick();
        @(negedge rclk);
        cyc++;
        if (rinc0 && rempty0) empty_viol++;
        if (rinc1 && rempty1) empty_viol++;
        if (pv0 && !pr0 && !(v0 && d0 == pd0 && l0 == pl0)) stable_viol++;
        pv0 = v0; pr0 = r0; pd0 = d0; pl0 = l0;
        if (v0 && r0) begin
            g0d.push_back({24'h0, d0});
            g0l.push_back(l0);
            g0c.push_back(cyc);
            if (l0 && first_done_pops < 0) first_done_pops = pops0;
        end
        if (v1 && r1) begin
            g1d.push_back(d1);
            g1l.push_back(l1);
            g1c.push_back(cyc);
        end
        if (rinc0) pops0++;
        pend0 = rinc0;
        pend1 = rinc1;
        @(posedge rclk);
        #1;
        if (pend0 && f0.size() > 0) tmp = f0.pop_front();
        if (pend1 && f1.size() > 0) tmp = f1.pop_front();
        drive_fifo();
    endtask

    task automatic clear_got();
        g0d.delete(); g0l.delete(); g0c.delete();
        g1d.delete(); g1l.delete(); g1c.delete();
        exp_w.delete();
    endtask

    task automatic check_stream0(input string tag, input bit nobub);
        int n;
        logic [31:0] w;
        chk($sformatf("%s count", tag), g0d.size(), exp_w.size() * 4);
        n = (g0d.size() < exp_w.size() * 4) ? g0d.size() : exp_w.size() * 4;
        for (int i = 0; i < n; i++) begin
            w = exp_w[i/4];
            chk($sformatf("%s data%0d", tag, i), g0d[i], (w >> (8 * (i % 4))) & 32'hff);
            chk($sformatf("%s last%0d", tag, i), {31'h0, g0l[i]}, ((i % 4) == 3) ? 32'd1 : 32'd0);
            if (nobub && i > 0) chk($sformatf("%s gap%0d", tag, i), g0c[i] - g0c[i-1], 1);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; pops0 = 0; first_done_pops = -1;
        stable_viol = 0; empty_viol = 0;
        pv0 = 0; pr0 = 0; pl0 = 0; pd0 = 0; pend0 = 0; pend1 = 0;
        rrst_n = 1'b0; r0 = 1'b0; r1 = 1'b0;
        f0.push_back(32'hA1B2C3D4);
        drive_fifo();

        // reset held with a non-empty FIFO
        r0 = 1'b1;
        repeat (4) begin
            tick();
            chk("rst rinc", rinc0, 0);
            chk("rst valid", v0, 0);
            chk("rst data", d0, 0);
            chk("rst last", l0, 0);
        end

        // single word after release
        clear_got();
        exp_w.push_back(32'hA1B2C3D4);
        pops0 = 0;
        c0 = cyc;
        rrst_n = 1'b1;
        repeat (8) tick();
        check_stream0("single", 1);
        if (g0c.size() > 0) chk("single latency", g0c[0] - c0, 2);
        chk("single pops", pops0, 1);
        chk("single idle", v0, 0);

        // back-to-back: beat k carries value k
        clear_got();
        for (int i = 0; i < 10; i++) begin
            tmp = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            f0.push_back(tmp);
            exp_w.push_back(tmp);
        end
        drive_fifo();
        repeat (50) tick();
        check_stream0("b2b", 1);
        chk("b2b idle", v0, 0);

        // backpressure: long stall then random ready
        clear_got();
        r0 = 1'b0;
        f0.push_back(32'h11223344); exp_w.push_back(32'h11223344);
        f0.push_back(32'h55667788); exp_w.push_back(32'h55667788);
        f0.push_back(32'h99AABBCC); exp_w.push_back(32'h99AABBCC);
        drive_fifo();
        pops0 = 0; first_done_pops = -1; stable_viol = 0;
        repeat (20) tick();
        chk("bp pops held", pops0, 2);
        chk("bp valid held", v0, 1);
        chk("bp data held", d0, 8'h44);
        budget = 0;
        while (g0d.size() < 12 && budget < 400) begin
            r0 = 1'($urandom_range(0, 1));
            tick();
            budget++;
        end
        chk("bp done in budget", (budget < 400) ? 1 : 0, 1);
        r0 = 1'b1;
        repeat (3) tick();
        check_stream0("bp", 0);
        chk("bp pops before first done", first_done_pops, 2);
        chk("bp total pops", pops0, 3);
        chk("bp stable", stable_viol, 0);

        // reset in the middle of a word
        clear_got();
        f0.push_back(32'hDEADBEEF);
        drive_fifo();
        budget = 0;
        while (g0d.size() < 2 && budget < 20) begin
            tick();
            budget++;
        end
        chk("mid reached beat1", g0d.size(), 2);
        chk("mid valid before", v0, 1);
        chk("mid data before", d0, 8'hAD);
        rrst_n = 1'b0;
        f0.delete(); f1.delete();
        drive_fifo();
        #1;
        chk("mid valid drop", v0, 0);
        chk("mid data drop", d0, 0);
        chk("mid rinc drop", rinc0, 0);
        repeat (2) tick();
        rrst_n = 1'b1;
        repeat (5) tick();
        chk("mid idle valid", v0, 0);
        chk("mid no extra beats", g0d.size(), 2);
        clear_got();
        f0.push_back(32'h55667788); exp_w.push_back(32'h55667788);
        drive_fifo();
        repeat (8) tick();
        check_stream0("post", 1);

        // RATIO=1 instance: 2-deep show-ahead buffer
        clear_got();
        r1 = 1'b1;
        for (int i = 0; i < 16; i++) f1.push_back(32'hC0DE0000 | 32'(i * 3));
        drive_fifo();
        repeat (24) tick();
        chk("r1 count", g1d.size(), 16);
        for (int i = 0; i < 16 && i < g1d.size(); i++) begin
            chk($sformatf("r1 data%0d", i), g1d[i], 32'hC0DE0000 | 32'(i * 3));
            chk($sformatf("r1 last%0d", i), {31'h0, g1l[i]}, 1);
            if (i > 0) chk($sformatf("r1 gap%0d", i), g1c[i] - g1c[i-1], 1);
        end
        chk("r1 idle", v1, 0);

        chk("rinc while empty", empty_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_serializer.md
# fifo_rd_serializer

Read-side consumer stage for the asynchronous FIFO, in the read clock domain. It pops full-width words from the FIFO's read port (rinc/rdata/rempty) and emits them as a stream of narrower beats on a valid/ready interface, least-significant slice first. A last flag marks the final beat of each word. A one-word prefetch buffer hides pop latency, so back-to-back words stream with no bubble while the FIFO is non-empty.

## Interface
- DSIZE, 32, FIFO word width; must equal the FIFO's DSIZE.
- OSIZE, 8, output beat width; DSIZE must be an integer multiple of OSIZE.
- RATIO, DSIZE/OSIZE (derived localparam), beats per word; counter width is max(1, clog2(RATIO)).
- rclk  in  1  read-domain clock; all state on its rising edge.
- rrst_n  in  1  reset, asynchronous and active-low; same net as the FIFO read reset.
- rempty  in  1  FIFO empty flag; rdata is valid whenever rempty=0.
- rdata  in  DSIZE  FIFO head word (show-ahead; updates after each pop).
- rinc  out  DSIZE-independent 1  pop strobe to the FIFO.
- o_valid  out  1  beat available.
- o_ready  in  1  downstream accepts beat; a transfer occurs when o_valid & o_ready on a rclk edge.
- o_data  out  OSIZE  current beat.
- o_last  out  1  high on the final beat (index RATIO-1) of a word.

## Operation
- Storage:
  - Shift stage: word register sh_word, sh_vld, beat index idx.
  - Prefetch stage: pf_word, pf_vld.
- Output mapping: o_valid=sh_vld; o_data=sh_word[idx*OSIZE +: OSIZE]; o_last=sh_vld & (idx==RATIO-1).
- Word-done event: wdone = o_valid & o_ready & o_last.
- Pop rule: rinc = rrst_n & !rempty & (!pf_vld | !sh_vld | wdone). rinc is never asserted while rempty=1. rinc is combinational from rempty, pf_vld, sh_vld and o_ready.
- On transfer without wdone: idx increments; sh_word is held.
- Shift-stage load (occurs when !sh_vld or wdone), in priority order:
  - pf_vld=1: pf_word moves to sh_word, idx=0, sh_vld=1. If rinc is also high, the popped word fills pf_word (pf_vld stays 1); otherwise pf_vld clears.
  - pf_vld=0 and rinc=1: rdata loads directly into sh_word, idx=0, sh_vld=1.
  - Neither: sh_vld clears.
- Pop while the shift stage is busy and not finishing: rdata goes to pf_word, pf_vld=1.
- Capacity: exactly two words held locally. Words are never dropped or duplicated, and order is preserved.
- RATIO=1: every beat has o_last=1, and the block acts as a 2-deep show-ahead buffer.
- Stalls:
  - o_ready may deassert at any time.
  - While o_valid=1, o_data, o_last and idx hold stable until a transfer occurs.
  - o_valid does not drop without a transfer (AXI-stream rules).
- Reset, asserted at any time including mid-word: sh_vld, pf_vld and idx clear immediately (asynchronously), and the data registers clear to 0. The partially sent word and the prefetched word are discarded; the FIFO is reset on the same net.

## Timing
- Reset values: o_valid=0, o_data=0, o_last=0, rinc=0.
- Fill latency, both stages empty: rempty falls in the cycle before edge E, so rinc=1 at E. o_valid=1 after E with beat 0 of that word, i.e. 1 rclk from the pop.
- Streaming: with o_ready held 1 and the FIFO non-empty, a beat transfers every rclk. Word N's last beat is followed on the next cycle by beat 0 of word N+1, with no bubble.
- Pops:
  - At most one word per rclk.
  - Sustained pop rate is 1 per RATIO cycles in steady state.
  - The prefetch refills in the same cycle it drains.
- FIFO empty mid-stream: after the last buffered word's final beat transfers, o_valid=0 on the next cycle.
- Simultaneous events in one cycle (wdone, pf→sh move and rinc) all occur together; no cycle is lost.

## Test plan
- Reset: hold rrst_n=0 with a non-empty FIFO behind the block -> rinc=0, o_valid=0, o_data=0 throughout reset.
- Single word: FIFO holds 32'hA1B2C3D4, o_ready=1 -> one pop; 4 beats D4,C3,B2,A1 on consecutive cycles, o_last only on A1; then o_valid=0.
- Back-to-back: 10 words 0..9 written through async_fifo, o_ready=1 -> 40 consecutive beats with no gaps, o_last every 4th beat, values in order.
- Backpressure:
  - Stimulus: 3 words queued, o_ready toggled randomly, including low for 20 cycles.
  - Required: no more than 2 pops before the first word completes; o_data stable while stalled; all 12 beats delivered exactly once and in order; rinc never high while rempty=1.
- Reset mid-word: assert rrst_n=0 after beat 1 of a word -> o_valid drops immediately; after release with an empty FIFO, o_valid stays 0 until new data arrives; new data's first beat is index 0.
- RATIO=1 (OSIZE=32): 16 words -> 16 beats, all with o_last=1, data equal to the words in order, with no bubbles under o_ready=1.
